tlp_memwr_gen: RTL
==================

TLP_MEMWR_GEN -- requirements
Module: tlp_memwr_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, request address width.
REQ-002 Parameter DATA_WIDTH, default 256, request beat and TLP beat width.
REQ-003 Parameter CHUNK_MAX_BEATS, default 4, maximum payload beats per request.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1: decoded request valid.
REQ-007 Port in_ready, output, 1: request accepted when in_valid && in_ready.
REQ-008 Port in_addr, input, ADDR_WIDTH: byte address of the write.
REQ-009 Port in_length, input, 8: payload length in DW; legal range 1..32.
REQ-010 Port in_bdf, input, 16: requester ID.
REQ-011 Port in_is_memwrite, input, 1: request is a memory write.
REQ-012 Port in_wdata, input, DATA_WIDTH*CHUNK_MAX_BEATS: payload; beat k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 Port tlp_valid, output, 1: TLP beat valid.
REQ-014 Port tlp_ready, input, 1: downstream accepts the beat when tlp_valid && tlp_ready.
REQ-015 Port tlp_data, output, DATA_WIDTH: TLP beat.
REQ-016 Port tlp_sop, output, 1: beat is the header beat.
REQ-017 Port tlp_eop, output, 1: beat is the last beat of the TLP.
REQ-018 Port drop_cnt, output, 16: count of discarded requests, saturating.

Function
REQ-019 The FSM SHALL have three states: IDLE, HDR and DATA; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE, legal accept (in_is_memwrite=1, in_length 1..32): latch addr, length, bdf and wdata, then go to HDR on the next cycle.
REQ-021 IDLE, illegal accept (in_is_memwrite=0, in_length=0, or in_length>32): discard the request, stay in IDLE, and increment drop_cnt by 1, saturating at 16'hFFFF.
REQ-022 HDR: tlp_valid=1, tlp_sop=1, tlp_eop=0.
REQ-023 HDR header layout: tlp_data[31:0]=DW0, [63:32]=DW1, [95:64]=DW2, all remaining bits 0.
REQ-024 DW0 = {Fmt=3'b010, Type=5'b00000, 8'h00, 6'h00, Length[9:0] = zero-extended in_length}.
REQ-025 DW1 = {bdf[15:0], tag[7:0], LastBE, FirstBE=4'hF}; LastBE=4'hF if length>1, else 4'h0.
REQ-026 DW2 = {addr[31:2], 2'b00}; addr[1:0] is ignored.
REQ-027 Beat count nbeats = ceil(length/8) = (length+7)>>3, range 1..4.
REQ-028 HDR handshake: go to DATA with beat counter=0.
REQ-029 DATA: tlp_valid=1, tlp_sop=0, tlp_data = latched payload beat[beat counter].
REQ-030 DATA: tlp_eop=1 iff beat counter == nbeats-1.
REQ-031 DATA, non-last handshake: increment the beat counter.
REQ-032 DATA, last handshake: go to IDLE and increment tag by 1, wrapping 8'hFF to 8'h00.
REQ-033 While tlp_valid=1 and tlp_ready=0, tlp_data, tlp_sop, tlp_eop and the state SHALL hold stable.
REQ-034 Latency: request accepted at cycle N gives header tlp_valid at cycle N+1.
REQ-035 After the eop handshake, in_ready is 1 in the following cycle.
REQ-036 Payload DW beyond length within the final beat SHALL pass through unmodified; there is no masking.

Reset
REQ-037 While rst_n=0, regardless of state: state=IDLE, tlp_valid=0, tlp_sop=0, tlp_eop=0, tlp_data=0, tag=0, drop_cnt=0, beat counter=0, in_ready=1.
REQ-038 Reset asserted mid-TLP SHALL abandon the TLP, with no further beats emitted.

Structure
REQ-039 Package tlp_pkg SHALL hold: FMT_3DW_DATA, TYPE_MEM, MAX_PAYLOAD_DW=32, the state enum, and a header-pack function (addr, length, bdf, tag) -> 96-bit header.
REQ-040 No sub-module SHALL be used; the header is built by the package function from latched registers.

Verification
REQ-041 addr=32'h1000_0040, len=8, bdf=16'h0100, tlp_ready=1 -> 2 beats: header DW0=32'h4000_0008, DW1=32'h0100_00FF, DW2=32'h1000_0040; then beat0 data with eop=1.
REQ-042 len=32 with tlp_ready toggling 1/0 -> 5 beats, eop on beat 5, each beat held stable while stalled, data beats equal the wdata slices 0..3.
REQ-043 len=1 -> header LastBE=4'h0, FirstBE=4'hF; 2 beats total.
REQ-044 Three requests with in_is_memwrite=0, len=0 and len=33 -> no tlp_valid, drop_cnt=3; then a legal request -> tag=0.
REQ-045 257 legal TLPs -> tag on the 257th = 8'h00.
REQ-046 rst_n pulsed low during DATA -> tlp_valid=0 immediately, in_ready=1, tag=0.

Source files
------------

// File: rtl/tlp_pkg.sv
// Shared definitions for the memory-write TLP generator: header field
// constants, the FSM state type and the 3DW header packing helper.
package tlp_pkg;

    localparam logic [2:0]  FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0]  TYPE_MEM       = 5'b00000;
    localparam int unsigned MAX_PAYLOAD_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Builds the 96-bit header {DW2, DW1, DW0} for a 3DW memory write.
    // The address is DW aligned, so its two low bits are dropped.
    function automatic logic [95:0] hdr_pack(
        input logic [31:0] addr,
        input logic [7:0]  length,
        input logic [15:0] bdf,
        input logic [7:0]  tag
    );
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        logic [3:0]  last_be;
        if (length > 8'd1) begin
            last_be = 4'hF;
        end else begin
            last_be = 4'h0;
        end
        dw0 = {FMT_3DW_DATA, TYPE_MEM, 8'h00, 6'h00, {2'b00, length}};
        dw1 = {bdf, tag, last_be, 4'hF};
        dw2 = {addr[31:2], 2'b00};
        return {dw2, dw1, dw0};
    endfunction

endpackage

// File: rtl/tlp_memwr_gen.sv
// Turns decoded write requests into a header beat followed by 1..4
// payload beats. Illegal requests are discarded and counted.
module tlp_memwr_gen
    import tlp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADDR_WIDTH-1:0]                 in_addr,
    input  logic [7:0]                            in_length,
    input  logic [15:0]                           in_bdf,
    input  logic                                  in_is_memwrite,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] in_wdata,
    output logic                                  tlp_valid,
    input  logic                                  tlp_ready,
    output logic [DATA_WIDTH-1:0]                 tlp_data,
    output logic                                  tlp_sop,
    output logic                                  tlp_eop,
    output logic [15:0]                           drop_cnt
);

    localparam int BEAT_W = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [15:0]           bdf_q;
    logic [7:0]            tag_q;
    logic [7:0]            tag_d;
    logic [15:0]           drop_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     beat_d;
    logic [DATA_WIDTH-1:0] payload_q [CHUNK_MAX_BEATS];

    logic                  legal_s;
    logic                  latch_s;
    logic                  drop_inc_s;
    logic                  last_beat_s;
    logic [7:0]            nbeats_s;
    logic [7:0]            beat_ext_s;
    logic [31:0]           addr32_s;
    logic [95:0]           hdr_s;

    // Request legality, beat bookkeeping and the header from latched fields.
    always_comb begin
        legal_s     = in_is_memwrite && (in_length != 8'd0) &&
                      (in_length <= 8'(MAX_PAYLOAD_DW));
        nbeats_s    = (len_q + 8'd7) >> 3'd3;
        beat_ext_s  = 8'(beat_q);
        last_beat_s = (beat_ext_s == (nbeats_s - 8'd1));
        addr32_s    = 32'(addr_q);
        hdr_s       = hdr_pack(addr32_s, len_q, bdf_q, tag_q);
    end

    // Next-state logic: accept/drop in IDLE, walk header then payload beats.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tag_d      = tag_q;
        latch_s    = 1'b0;
        drop_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (legal_s) begin
                        latch_s = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tlp_ready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (tlp_ready) begin
                    if (last_beat_s) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        tag_d   = tag_q + 8'd1;
                    end else begin
                        beat_d = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State, beat counter and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            tag_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
        end
    end

    // Captures the request fields and payload on a legal accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            len_q  <= 8'd0;
            bdf_q  <= 16'h0000;
            for (int k = 0; k < CHUNK_MAX_BEATS; k++) begin
                payload_q[k] <= '0;
            end
        end else if (latch_s) begin
            addr_q <= in_addr;
            len_q  <= in_length;
            bdf_q  <= in_bdf;
            for (int k = 0; k < CHUNK_MAX_BEATS; k++) begin
                payload_q[k] <= in_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Saturating count of discarded requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'h0000;
        end else if (drop_inc_s && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'h0001;
        end
    end

    // Output decode from registered state only, so beats hold while stalled.
    always_comb begin
        in_ready  = 1'b0;
        tlp_valid = 1'b0;
        tlp_sop   = 1'b0;
        tlp_eop   = 1'b0;
        tlp_data  = '0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_HDR: begin
                tlp_valid = 1'b1;
                tlp_sop   = 1'b1;
                tlp_data  = DATA_WIDTH'(hdr_s);
            end
            ST_DATA: begin
                tlp_valid = 1'b1;
                tlp_eop   = last_beat_s;
                tlp_data  = payload_q[beat_q];
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign drop_cnt = drop_q;

endmodule
